// File: rtl/lmi_iram_fetch_ctl.sv
// lmi_iram_fetch_ctl
//   Instruction-fetch steering stage placed after the LMI IRAM range
//   comparator. Hits are served from the local IRAM (1-cycle synchronous
//   read). Misses go to the external bus over a req/ack handshake. A
//   single in-order response stream is returned to the fetch unit, and
//   the stream can be flushed.
//
// Ports
//   clk, reset              sole clock; synchronous active-high reset
//   fetch_req/addr/gnt      fetch request, byte address, combinational grant
//   fetch_valid/data/err    response stream (err qualified by valid)
//   flush                   drop every accepted fetch not yet returned
//   iram_hit                comparator hit for fetch_addr, same cycle
//   iram_cs/addr/rdata      IRAM read port (rdata valid the cycle after cs)
//   bus_req/addr            registered external read request
//   bus_ack/rdata/err       external read completion
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | nothing outstanding; may accept a request
// IRAM_RD   | IRAM data returns this cycle; may accept a request
// BUS_WAIT  | bus read outstanding; the response is still wanted
// BUS_DROP  | bus read outstanding after a flush; the result is discarded
// BUS_RESP  | buffered bus data returns this cycle; may accept a request

module lmi_iram_fetch_ctl #(
  parameter int IRAM_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_valid,
  output logic [31:0]        fetch_data,
  output logic               fetch_err,
  input  logic               flush,
  input  logic               iram_hit,
  output logic               iram_cs,
  output logic [IRAM_AW-1:0] iram_addr,
  input  logic [31:0]        iram_rdata,
  output logic               bus_req,
  output logic [31:0]        bus_addr,
  input  logic               bus_ack,
  input  logic [31:0]        bus_rdata,
  input  logic               bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    IRAM_RD,
    BUS_WAIT,
    BUS_DROP,
    BUS_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] rd_buf;
  logic        err_q;
  logic        miss_acc;   // miss granted: launch the bus request
  logic        ack_take;   // ack whose data will be returned
  logic        ack_done;   // any ack that ends the bus transaction

  assign iram_addr = fetch_addr[IRAM_AW+1:2];

  always_comb begin
    state_nxt   = state;
    fetch_gnt   = 1'b0;
    iram_cs     = 1'b0;
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    fetch_data  = rd_buf;
    miss_acc    = 1'b0;
    ack_take    = 1'b0;
    ack_done    = 1'b0;

    case (state)
      IDLE, IRAM_RD, BUS_RESP: begin
        fetch_gnt = fetch_req & ~flush;
        if (state == IRAM_RD) begin
          fetch_valid = ~flush;
          fetch_data  = iram_rdata;
        end
        if (state == BUS_RESP) begin
          fetch_valid = ~flush;
          fetch_err   = ~flush & err_q;
        end
        if (fetch_gnt) begin
          if (iram_hit) begin
            iram_cs   = 1'b1;
            state_nxt = IRAM_RD;
          end else begin
            miss_acc  = 1'b1;
            state_nxt = BUS_WAIT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUS_WAIT: begin
        if (bus_ack) begin
          ack_done = 1'b1;
          if (flush) begin
            state_nxt = IDLE;
          end else begin
            ack_take  = 1'b1;
            state_nxt = BUS_RESP;
          end
        end else if (flush) begin
          // The request stays up; the bus has no way to cancel it.
          state_nxt = BUS_DROP;
        end
      end
      BUS_DROP: begin
        if (bus_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (reset) begin
      state_nxt   = IDLE;
      fetch_gnt   = 1'b0;
      iram_cs     = 1'b0;
      fetch_valid = 1'b0;
      fetch_err   = 1'b0;
      fetch_data  = '0;
      miss_acc    = 1'b0;
      ack_take    = 1'b0;
      ack_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      rd_buf   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (miss_acc) begin
        bus_req  <= 1'b1;
        bus_addr <= fetch_addr & 32'hFFFF_FFFC;
      end else if (ack_done) begin
        bus_req  <= 1'b0;
      end
      if (ack_take) begin
        rd_buf <= bus_rdata;
        err_q  <= bus_err;
      end
    end
  end

endmodule

// File: tb/tb_lmi_iram_fetch_ctl.sv
// tb_lmi_iram_fetch_ctl
//   Directed bench for lmi_iram_fetch_ctl. Expected responses are queued
//   when a request is granted and compared by a monitor when fetch_valid
//   is seen. IRAM contents are a fixed function of the word address.

module tb_lmi_iram_fetch_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        flush = 1'b0;
  logic        iram_hit = 1'b0;
  logic        iram_cs;
  logic [11:0] iram_addr;
  logic [31:0] iram_rdata = '0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_resp  = 0;
  logic [32:0] sb[$];

  lmi_iram_fetch_ctl #(.IRAM_AW(12)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .flush(flush), .iram_hit(iram_hit),
    .iram_cs(iram_cs), .iram_addr(iram_addr), .iram_rdata(iram_rdata),
    .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] iram_word(input logic [11:0] a);
    return {20'hA5C3E, a};
  endfunction

  always @(posedge clk) if (iram_cs) iram_rdata <= iram_word(iram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fetch_valid !== 1'b0) begin
      n_resp++;
      n_tests++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_valid observed=%b expected=0", fetch_valid);
      end
      if (sb.size() != 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("resp_data", fetch_data, e[31:0]);
        chk("resp_err", {31'b0, fetch_err}, {31'b0, e[32]});
      end
    end
  end

  task automatic cyc(input logic r, input logic req, input logic [31:0] a,
                     input logic hit, input logic fl, input logic ack,
                     input logic [31:0] bd, input logic be);
    @(posedge clk);
    #1;
    reset = r; fetch_req = req; fetch_addr = a; iram_hit = hit;
    flush = fl; bus_ack = ack; bus_rdata = bd; bus_err = be;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic hit_req(input logic [31:0] a, input bit expect_resp);
    cyc(0, 1, a, 1, 0, 0, 32'h0, 0);
    chk("hit_gnt", {31'b0, fetch_gnt}, 32'd1);
    chk("hit_cs", {31'b0, iram_cs}, 32'd1);
    if (expect_resp) sb.push_back({1'b0, iram_word(a[13:2])});
  endtask

  initial begin
    // reset
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    idle();
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_busreq", {31'b0, bus_req}, 32'd0);
    chk("rst_busaddr", bus_addr, 32'h0);
    chk("rst_data", fetch_data, 32'h0);
    chk("rst_cs", {31'b0, iram_cs}, 32'd0);
    chk("rst_gnt", {31'b0, fetch_gnt}, 32'd0);

    // 1: back-to-back hits
    hit_req(32'h0000_1000, 1); chk("iram_addr0", {20'b0, iram_addr}, 32'h400);
    hit_req(32'h0000_1004, 1); chk("iram_addr1", {20'b0, iram_addr}, 32'h401);
    hit_req(32'h0000_1008, 1); chk("iram_addr2", {20'b0, iram_addr}, 32'h402);
    idle(); idle();
    chk("t1_resp", n_resp, 32'd3);

    // 2: miss, ack after 3 wait cycles
    cyc(0, 1, 32'h8000_0040, 0, 0, 0, 32'h0, 0);
    chk("miss_gnt", {31'b0, fetch_gnt}, 32'd1);
    chk("miss_cs", {31'b0, iram_cs}, 32'd0);
    sb.push_back({1'b0, 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h0000_1100, 1, 0, 0, 32'h0, 0);
      chk("wait_gnt", {31'b0, fetch_gnt}, 32'd0);
      chk("wait_req", {31'b0, bus_req}, 32'd1);
      chk("wait_addr", bus_addr, 32'h8000_0040);
    end
    cyc(0, 0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("ack_req", {31'b0, bus_req}, 32'd1);
    chk("ack_addr", bus_addr, 32'h8000_0040);
    idle();
    chk("resp_busreq", {31'b0, bus_req}, 32'd0);
    idle();
    chk("t2_resp", n_resp, 32'd4);

    // 3: miss with bus error (unaligned low bits dropped), hit in BUS_RESP
    cyc(0, 1, 32'h9000_0006, 0, 0, 0, 32'h0, 0);
    sb.push_back({1'b1, 32'h1234_5678});
    cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    chk("err_addr", bus_addr, 32'h9000_0004);
    cyc(0, 0, 32'h0, 0, 0, 1, 32'h1234_5678, 1);
    hit_req(32'h0000_1010, 1);
    idle(); idle();
    chk("t3_resp", n_resp, 32'd6);

    // 4: miss then flush; ack arrives late and is discarded
    cyc(0, 1, 32'hA000_0100, 0, 0, 0, 32'h0, 0);
    chk("t4_gnt", {31'b0, fetch_gnt}, 32'd1);
    cyc(0, 1, 32'h0000_1200, 1, 1, 0, 32'h0, 0);
    chk("fl_req", {31'b0, bus_req}, 32'd1);
    chk("fl_gnt", {31'b0, fetch_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'h0000_1200, 1, 0, 0, 32'h0, 0);
      chk("drop_req", {31'b0, bus_req}, 32'd1);
      chk("drop_gnt", {31'b0, fetch_gnt}, 32'd0);
    end
    cyc(0, 1, 32'h0000_1200, 1, 0, 1, 32'hBAD0_BAD0, 1);
    chk("drop_ack_gnt", {31'b0, fetch_gnt}, 32'd0);
    hit_req(32'h0000_1020, 1);
    chk("post_drop_req", {31'b0, bus_req}, 32'd0);
    idle(); idle();
    chk("t4_resp", n_resp, 32'd7);

    // 5: flush in the IRAM_RD cycle with a request present
    hit_req(32'h0000_1030, 0);
    cyc(0, 1, 32'h0000_1034, 1, 1, 0, 32'h0, 0);
    chk("fl_rd_valid", {31'b0, fetch_valid}, 32'd0);
    chk("fl_rd_gnt", {31'b0, fetch_gnt}, 32'd0);
    idle();
    chk("fl_idle_valid", {31'b0, fetch_valid}, 32'd0);
    hit_req(32'h0000_1040, 1);
    idle(); idle();
    chk("t5_resp", n_resp, 32'd8);

    // 6: reset during BUS_WAIT, then a late ack
    cyc(0, 1, 32'hB000_0000, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    chk("t6_req", {31'b0, bus_req}, 32'd1);
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 0, 0, 1, 32'h5555_AAAA, 1);
    chk("t6_busreq", {31'b0, bus_req}, 32'd0);
    chk("t6_busaddr", bus_addr, 32'h0);
    chk("t6_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t6_data", fetch_data, 32'h0);
    chk("t6_err", {31'b0, fetch_err}, 32'd0);
    idle();
    chk("t6_valid2", {31'b0, fetch_valid}, 32'd0);
    idle();

    chk("final_resp", n_resp, 32'd8);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lmi_iram_fetch_ctl.md
Name: lmi_iram_fetch_ctl

Overview:
Instruction-fetch steering stage directly downstream of the LMI IRAM range comparator.
- Accepts one fetch request per cycle and takes the comparator's hit flag for the same address.
- Routes hits to the local IRAM (synchronous, 1-cycle read) and misses to the external bus (req/ack handshake).
- Returns a single in-order response stream to the fetch unit and supports pipeline flush.

Parameters:
IRAM_AW, 12, IRAM word-address width; IRAM_ADDR = FETCH_ADDR[IRAM_AW+1:2]

Ports:
CLK  input  1  sole clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
FETCH_REQ  input  1  fetch request valid
FETCH_ADDR  input  32  fetch byte address (word aligned; [1:0] ignored)
FETCH_GNT  output  1  request accepted this cycle (combinational)
FETCH_VALID  output  1  response valid (one cycle per accepted, unflushed request)
FETCH_DATA  output  32  instruction word
FETCH_ERR  output  1  bus error on this response; qualified by FETCH_VALID
FLUSH  input  1  discard all accepted-but-unreturned fetches
IRAM_HIT  input  1  comparator CMP for FETCH_ADDR, same cycle
IRAM_CS  output  1  IRAM read strobe
IRAM_ADDR  output  IRAM_AW  IRAM word address
IRAM_RDATA  input  32  IRAM read data, valid the cycle after IRAM_CS
BUS_REQ  output  1  external read request (registered)
BUS_ADDR  output  32  external read address (registered)
BUS_ACK  input  1  bus completes read this cycle
BUS_RDATA  input  32  bus read data, valid with BUS_ACK
BUS_ERR  input  1  bus error, valid with BUS_ACK

Behaviour:
- States: IDLE, IRAM_RD, BUS_WAIT, BUS_DROP, BUS_RESP.
- Reset: state IDLE. FETCH_VALID, FETCH_ERR, BUS_REQ, IRAM_CS, FETCH_GNT = 0. BUS_ADDR, FETCH_DATA, data buffer = 0. RESET overrides every other input, including mid-bus-transaction; the bus side must tolerate a dropped request.
- FETCH_GNT = FETCH_REQ & ~FLUSH & state in {IDLE, IRAM_RD, BUS_RESP}. It is 0 in BUS_WAIT and BUS_DROP.
- Accepted hit (GNT & IRAM_HIT):
  - IRAM_CS=1 and IRAM_ADDR driven in the same cycle; next state IRAM_RD.
  - In IRAM_RD: FETCH_VALID=1, FETCH_DATA=IRAM_RDATA, FETCH_ERR=0. Latency 1 cycle.
  - Back-to-back hits give one response per cycle.
- Accepted miss (GNT & ~IRAM_HIT):
  - Latch FETCH_ADDR with bits [1:0] forced to 0 into BUS_ADDR; BUS_REQ=1 from the next cycle; next state BUS_WAIT.
  - BUS_REQ and BUS_ADDR stay stable until the BUS_ACK cycle; BUS_REQ drops the cycle after ack.
  - On BUS_ACK: latch BUS_RDATA and BUS_ERR, go to BUS_RESP.
  - In BUS_RESP: FETCH_VALID=1, FETCH_DATA=buffer, FETCH_ERR=latched err. Miss latency = 2 + bus wait cycles from grant to valid.
- Idle: no grant in IDLE/IRAM_RD/BUS_RESP -> next state IDLE; FETCH_VALID=0 in IDLE.
- BUS_ACK is ignored unless state is BUS_WAIT or BUS_DROP.
- FLUSH (highest priority after RESET):
  - IDLE: no grant.
  - IRAM_RD / BUS_RESP: FETCH_VALID forced 0 this cycle, no grant, next state IDLE.
  - BUS_WAIT without BUS_ACK: BUS_REQ held (never withdrawn), next state BUS_DROP.
  - BUS_WAIT with BUS_ACK: data discarded, next IDLE.
  - BUS_DROP: waits for BUS_ACK, discards data and error, no FETCH_VALID, then IDLE.
- FLUSH and FETCH_REQ in the same cycle: the request is not granted.
- FETCH_DATA outside FETCH_VALID is don't-care, but must not be X after reset.
- Invariant: at most one bus transaction outstanding. Responses are strictly in grant order.

Test Plan:
1. Reset, then hits at 0x0000_1000, 0x0000_1004, 0x0000_1008 on consecutive cycles -> GNT=1 each cycle; IRAM_ADDR 0x400, 0x401, 0x402; FETCH_VALID on the 3 following cycles with IRAM_RDATA values in order.
2. Miss 0x8000_0040, BUS_ACK after 3 wait cycles with data 0xDEADBEEF -> BUS_ADDR=0x8000_0040 stable 4 cycles; FETCH_VALID one cycle after ack with 0xDEADBEEF, ERR=0; GNT=0 throughout BUS_WAIT.
3. Miss with BUS_ERR=1 at ack -> single response with FETCH_ERR=1. A following hit is granted in the BUS_RESP cycle and returns normally.
4. Miss, then FLUSH 1 cycle later, ack 5 cycles later -> BUS_REQ stays high until ack; no FETCH_VALID; GNT=0 until back in IDLE; the next request proceeds normally.
5. Hit granted, FLUSH in the IRAM_RD cycle with FETCH_REQ=1 -> FETCH_VALID=0, GNT=0, state IDLE.
6. RESET asserted while in BUS_WAIT -> next cycle all outputs 0, state IDLE; a late BUS_ACK produces no FETCH_VALID.
